// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 frame receiver:
// register map, frame width and receiver FSM states.
package max7219_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/max7219_spi_rx_if.sv
// Three-wire SPI link (mode 0) between a MAX7219 driver
// and a receiver; master drives, slave listens.
interface max7219_spi_rx_if;

  logic i_sck;
  logic i_cs;
  logic i_mosi;

  modport master (
    output i_sck,
    output i_cs,
    output i_mosi
  );

  modport slave (
    input i_sck,
    input i_cs,
    input i_mosi
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async pin, followed by
// a history flop that yields rise/fall strobes.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (res) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/max7219_spi_rx.sv
// MAX7219 frame receiver: shifts 16-bit SPI frames and keeps
// a shadow copy of the display driver register file.
module max7219_spi_rx
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                res,
  max7219_spi_rx_if.slave     i_spi,
  output logic                o_frame_valid,
  output logic [3:0]          o_addr,
  output logic [7:0]          o_data,
  output logic                o_frame_err,
  output logic [63:0]         o_digits,
  output logic [7:0]          o_decode_mode,
  output logic [3:0]          o_intensity,
  output logic [2:0]          o_scan_limit,
  output logic                o_shutdown_n,
  output logic                o_display_test
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  state_t                  r_state;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [CNT_W-1:0]        r_cnt;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;

  logic                    w_sck_rise;
  logic                    w_unused_sck_q;
  logic                    w_unused_sck_fall;
  logic                    w_cs;
  logic                    w_cs_rise;
  logic                    w_cs_fall;
  logic                    w_mosi;
  logic                    w_unused_msb;
  logic [CNT_W-1:0]        w_cnt_nx;
  logic [CNT_W-1:0]        w_cnt_first;
  logic [FRAME_BITS-1:0]   w_shifted;
  logic [FRAME_BITS-1:0]   w_shreg_nx;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk    (clk),
    .res    (res),
    .i_d    (i_spi.i_sck),
    .o_q    (w_unused_sck_q),
    .o_rise (w_sck_rise),
    .o_fall (w_unused_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk    (clk),
    .res    (res),
    .i_d    (i_spi.i_cs),
    .o_q    (w_cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // mosi tapped at the same depth as sck so the bit lines up with its edge
  always_ff @(posedge clk) begin
    if (res) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi.i_mosi};
    end
  end

  assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
  assign w_unused_msb = r_shreg[FRAME_BITS-1];

  always_comb begin
    w_shifted   = {r_shreg[FRAME_BITS-2:0], w_mosi};
    w_shreg_nx  = r_shreg;
    w_cnt_nx    = r_cnt;
    w_cnt_first = '0;
    if (w_sck_rise) begin
      w_shreg_nx  = w_shifted;
      w_cnt_first = CNT_W'(1);
      if (r_cnt != CNT_MAX) begin
        w_cnt_nx = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state        <= WAIT_IDLE;
      r_shreg        <= '0;
      r_cnt          <= '0;
      o_frame_valid  <= 1'b0;
      o_frame_err    <= 1'b0;
      o_addr         <= '0;
      o_data         <= '0;
      o_digits       <= '0;
      o_decode_mode  <= '0;
      o_intensity    <= '0;
      o_scan_limit   <= '0;
      o_shutdown_n   <= 1'b0;
      o_display_test <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      unique case (r_state)
        WAIT_IDLE: begin
          if (w_cs) r_state <= IDLE;
        end
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= SHIFT;
            r_cnt   <= w_cnt_first;
            r_shreg <= w_shreg_nx;
          end
        end
        SHIFT: begin
          r_cnt   <= w_cnt_nx;
          r_shreg <= w_shreg_nx;
          if (w_cs_rise) begin
            if (w_cnt_nx == CNT_FULL) begin
              r_state <= COMMIT;
            end else begin
              o_frame_err <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        COMMIT: begin
          o_frame_valid <= 1'b1;
          o_addr        <= r_shreg[11:8];
          o_data        <= r_shreg[7:0];
          unique case (r_shreg[11:8])
            ADDR_NOOP:      ;
            ADDR_DIGIT0:    o_digits[7:0]   <= r_shreg[7:0];
            ADDR_DIGIT1:    o_digits[15:8]  <= r_shreg[7:0];
            ADDR_DIGIT2:    o_digits[23:16] <= r_shreg[7:0];
            ADDR_DIGIT3:    o_digits[31:24] <= r_shreg[7:0];
            ADDR_DIGIT4:    o_digits[39:32] <= r_shreg[7:0];
            ADDR_DIGIT5:    o_digits[47:40] <= r_shreg[7:0];
            ADDR_DIGIT6:    o_digits[55:48] <= r_shreg[7:0];
            ADDR_DIGIT7:    o_digits[63:56] <= r_shreg[7:0];
            ADDR_DECODE:    o_decode_mode   <= r_shreg[7:0];
            ADDR_INTENSITY: o_intensity     <= r_shreg[3:0];
            ADDR_SCANLIM:   o_scan_limit    <= r_shreg[2:0];
            ADDR_SHUTDOWN:  o_shutdown_n    <= r_shreg[0];
            ADDR_TEST:      o_display_test  <= r_shreg[0];
            default:        ;
          endcase
          // a new frame may already be starting while this one commits
          if (w_cs_fall) begin
            r_state <= SHIFT;
            r_cnt   <= w_cnt_first;
            r_shreg <= w_shreg_nx;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Randomised bench for max7219_spi_rx against a register-file
// model driven by whole SPI frames.
module tb_max7219_spi_rx;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        o_frame_valid;
  logic [3:0]  o_addr;
  logic [7:0]  o_data;
  logic        o_frame_err;
  logic [63:0] o_digits;
  logic [7:0]  o_decode_mode;
  logic [3:0]  o_intensity;
  logic [2:0]  o_scan_limit;
  logic        o_shutdown_n;
  logic        o_display_test;

  always #5 clk = ~clk;

  max7219_spi_rx_if u_if ();

  max7219_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .res            (res),
    .i_spi          (u_if),
    .o_frame_valid  (o_frame_valid),
    .o_addr         (o_addr),
    .o_data         (o_data),
    .o_frame_err    (o_frame_err),
    .o_digits       (o_digits),
    .o_decode_mode  (o_decode_mode),
    .o_intensity    (o_intensity),
    .o_scan_limit   (o_scan_limit),
    .o_shutdown_n   (o_shutdown_n),
    .o_display_test (o_display_test)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int exp_valid = 0;
  int exp_err   = 0;
  int cyc = 0;
  int valid_cyc = 0;
  int cs_rise_cyc = 0;

  logic [7:0] m_reg [16];
  logic [3:0] m_addr;
  logic [7:0] m_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_frame_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (o_frame_err === 1'b1) n_err++;
  end

  function automatic logic [63:0] exp_digits();
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = m_reg[k+1];
    return d;
  endfunction

  function automatic logic [16:0] exp_ctrl();
    return {m_reg[9], m_reg[10][3:0], m_reg[11][2:0],
            m_reg[12][0], m_reg[15][0]};
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {o_decode_mode, o_intensity, o_scan_limit,
            o_shutdown_n, o_display_test};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_reg[k] = 8'h00;
    m_addr = 4'h0;
    m_data = 8'h00;
  endtask

  task automatic model_frame(input logic [31:0] v, input int n);
    if (n == 16) begin
      exp_valid++;
      m_addr = v[11:8];
      m_data = v[7:0];
      m_reg[v[11:8]] = v[7:0];
    end else begin
      exp_err++;
    end
  endtask

  // lead: clk from cs fall to first sck rise (0 = same cycle)
  // lag: clk from last sck rise to cs rise (0 = same cycle)
  task automatic xfer(input logic [31:0] v, input int n,
                      input int lead, input int lag, input int gap);
    u_if.i_cs = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      u_if.i_mosi = v[i];
      if (i != n - 1) repeat (HALF) @(negedge clk);
      else if (lead > 0) repeat (lead) @(negedge clk);
      u_if.i_sck = 1'b1;
      if (i == 0 && lag == 0) begin
        u_if.i_cs   = 1'b1;
        cs_rise_cyc = cyc;
      end
      repeat (HALF) @(negedge clk);
      u_if.i_sck = 1'b0;
    end
    if (lag > 0) begin
      repeat (lag) @(negedge clk);
      u_if.i_cs   = 1'b1;
      cs_rise_cyc = cyc;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    u_if.i_cs   = 1'b1;
    u_if.i_sck  = 1'b0;
    u_if.i_mosi = 1'b0;
    res = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    n_tests++;
    if ({o_frame_valid, o_frame_err, o_addr, o_data} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_flags got %h exp 0",
               {o_frame_valid, o_frame_err, o_addr, o_data});
    end
    n_tests++;
    if ({o_digits, dut_ctrl()} !== 81'h0) begin
      n_fail++;
      $display("FAIL reset_regs got %h/%h exp 0", o_digits, dut_ctrl());
    end
    res = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (n_valid != 0 || n_err != 0) begin
      n_fail++;
      $display("FAIL reset_pulses got v=%0d e=%0d exp 0", n_valid, n_err);
    end
  endtask

  task automatic test_digit_write();
    logic [31:0] v;
    xfer(32'h0305, 16, HALF, HALF, 10);
    model_frame(32'h0305, 16);
    n_tests++;
    if (n_valid != exp_valid) begin
      n_fail++;
      $display("FAIL t1_valid got %0d exp %0d", n_valid, exp_valid);
    end
    n_tests++;
    if ({o_addr, o_data} !== 12'h305) begin
      n_fail++;
      $display("FAIL t1_addr_data got %h exp 305", {o_addr, o_data});
    end
    n_tests++;
    if (o_digits !== 64'h0000_0000_0005_0000) begin
      n_fail++;
      $display("FAIL t1_digits got %h exp %h", o_digits,
               64'h0000_0000_0005_0000);
    end
    n_tests++;
    if (valid_cyc - cs_rise_cyc != 4) begin
      n_fail++;
      $display("FAIL t1_latency got %0d exp 4", valid_cyc - cs_rise_cyc);
    end
    v = {16'h0, 4'($urandom), 4'($urandom_range(1, 8)), 8'($urandom)};
    xfer(v, 16, HALF, HALF, 10);
    model_frame(v, 16);
    n_tests++;
    if (o_digits !== exp_digits()) begin
      n_fail++;
      $display("FAIL t1_rand_digit got %h exp %h", o_digits, exp_digits());
    end
  endtask

  task automatic test_control_regs();
    logic [15:0] frames [5];
    logic [31:0] v;
    frames = '{16'h0C01, 16'h0A0F, 16'h0B07, 16'h09FF, 16'h0F01};
    for (int k = 0; k < 5; k++) begin
      xfer({16'h0, frames[k]}, 16, HALF, HALF, 10);
      model_frame({16'h0, frames[k]}, 16);
    end
    n_tests++;
    if (dut_ctrl() !== {8'hFF, 4'hF, 3'd7, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL t2_ctrl got %h exp %h", dut_ctrl(),
               {8'hFF, 4'hF, 3'd7, 1'b1, 1'b1});
    end
    v = {20'h0, 4'hA, 8'($urandom)};
    xfer(v, 16, HALF, HALF, 10);
    model_frame(v, 16);
    n_tests++;
    if (dut_ctrl() !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL t2_intensity got %h exp %h", dut_ctrl(), exp_ctrl());
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] v;
    v = {16'h0, 8'h01, 8'($urandom)};
    xfer(v, 15, HALF, HALF, 10);
    model_frame(v, 15);
    n_tests++;
    if (n_err != exp_err || n_valid != exp_valid) begin
      n_fail++;
      $display("FAIL t3_short got e=%0d v=%0d exp e=%0d v=%0d",
               n_err, n_valid, exp_err, exp_valid);
    end
    v = {15'h0, 1'b0, 8'h02, 8'($urandom)};
    xfer(v, 17, HALF, HALF, 10);
    model_frame(v, 17);
    n_tests++;
    if (n_err != exp_err || n_valid != exp_valid) begin
      n_fail++;
      $display("FAIL t3_long got e=%0d v=%0d exp e=%0d v=%0d",
               n_err, n_valid, exp_err, exp_valid);
    end
    n_tests++;
    if (o_digits !== exp_digits()) begin
      n_fail++;
      $display("FAIL t3_unchanged got %h exp %h", o_digits, exp_digits());
    end
    xfer(32'h0111, 16, HALF, HALF, 10);
    model_frame(32'h0111, 16);
    n_tests++;
    if (o_digits[7:0] !== 8'h11 || o_digits !== exp_digits()) begin
      n_fail++;
      $display("FAIL t3_recover got %h exp %h", o_digits, exp_digits());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] v;
    v = 16'($urandom);
    u_if.i_cs = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      u_if.i_mosi = v[i];
      repeat (HALF) @(negedge clk);
      u_if.i_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      u_if.i_sck = 1'b0;
      if (i == 8) begin
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        model_reset();
      end
    end
    repeat (HALF) @(negedge clk);
    u_if.i_cs = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (n_valid != exp_valid || n_err != exp_err) begin
      n_fail++;
      $display("FAIL t4_pulses got v=%0d e=%0d exp v=%0d e=%0d",
               n_valid, n_err, exp_valid, exp_err);
    end
    n_tests++;
    if ({o_digits, dut_ctrl(), o_addr, o_data} !== 93'h0) begin
      n_fail++;
      $display("FAIL t4_cleared got %h/%h/%h exp 0",
               o_digits, dut_ctrl(), {o_addr, o_data});
    end
    xfer(32'h0822, 16, HALF, HALF, 10);
    model_frame(32'h0822, 16);
    n_tests++;
    if (o_digits[63:56] !== 8'h22 || o_digits !== exp_digits()) begin
      n_fail++;
      $display("FAIL t4_after got %h exp %h", o_digits, exp_digits());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    xfer(32'h0101, 16, HALF, HALF, 2 * HALF);
    xfer(32'h0202, 16, HALF, HALF, 10);
    model_frame(32'h0101, 16);
    model_frame(32'h0202, 16);
    n_tests++;
    if (n_valid != exp_valid || o_digits[15:0] !== 16'h0201) begin
      n_fail++;
      $display("FAIL t5_b2b got v=%0d d=%h exp v=%0d d=0201",
               n_valid, o_digits[15:0], exp_valid);
    end
    a = {20'h0, 4'($urandom_range(1, 4)), 8'($urandom)};
    b = {20'h0, 4'($urandom_range(5, 8)), 8'($urandom)};
    xfer(a, 16, HALF, HALF, 1);
    xfer(b, 16, HALF, HALF, 10);
    model_frame(a, 16);
    model_frame(b, 16);
    n_tests++;
    if (n_valid != exp_valid || o_digits !== exp_digits()) begin
      n_fail++;
      $display("FAIL t5_commit_fall got v=%0d %h exp v=%0d %h",
               n_valid, o_digits, exp_valid, exp_digits());
    end
  endtask

  task automatic test_noop_unused();
    logic [63:0] d0;
    logic [16:0] c0;
    d0 = exp_digits();
    c0 = exp_ctrl();
    xfer(32'h00AA, 16, HALF, HALF, 10);
    model_frame(32'h00AA, 16);
    n_tests++;
    if ({o_addr, o_data} !== 12'h0AA || n_valid != exp_valid) begin
      n_fail++;
      $display("FAIL t6_noop got %h v=%0d exp 0aa v=%0d",
               {o_addr, o_data}, n_valid, exp_valid);
    end
    xfer(32'h0DAA, 16, HALF, HALF, 10);
    model_frame(32'h0DAA, 16);
    n_tests++;
    if ({o_addr, o_data} !== 12'hDAA || n_err != exp_err) begin
      n_fail++;
      $display("FAIL t6_unused got %h e=%0d exp daa e=%0d",
               {o_addr, o_data}, n_err, exp_err);
    end
    n_tests++;
    if (o_digits !== d0 || dut_ctrl() !== c0) begin
      n_fail++;
      $display("FAIL t6_regs got %h/%h exp %h/%h",
               o_digits, dut_ctrl(), d0, c0);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    v = {20'h0, 4'($urandom_range(1, 8)), 8'($urandom)};
    xfer(v, 16, 0, 0, 10);
    model_frame(v, 16);
    n_tests++;
    if (n_valid != exp_valid || n_err != exp_err ||
        o_digits !== exp_digits()) begin
      n_fail++;
      $display("FAIL sim_edges got v=%0d e=%0d %h exp v=%0d e=%0d %h",
               n_valid, n_err, o_digits, exp_valid, exp_err, exp_digits());
    end
  endtask

  task automatic test_random();
    int lens [7];
    int opts [3];
    int gaps [3];
    int n;
    int gap;
    logic [31:0] v;
    lens = '{16, 16, 16, 15, 17, 20, 8};
    opts = '{0, 1, HALF};
    gaps = '{1, HALF, 10};
    for (int it = 0; it < 30; it++) begin
      n   = lens[$urandom_range(0, 6)];
      gap = gaps[$urandom_range(0, 2)];
      v   = $urandom;
      xfer(v, n, opts[$urandom_range(0, 2)],
           opts[$urandom_range(0, 2)], gap);
      model_frame(v & ((n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 1)), n);
      if (gap >= 10) begin
        n_tests++;
        if (n_valid != exp_valid || n_err != exp_err) begin
          n_fail++;
          $display("FAIL rand_pulses it=%0d got v=%0d e=%0d exp v=%0d e=%0d",
                   it, n_valid, n_err, exp_valid, exp_err);
        end
        n_tests++;
        if (o_digits !== exp_digits() || dut_ctrl() !== exp_ctrl() ||
            {o_addr, o_data} !== {m_addr, m_data}) begin
          n_fail++;
          $display("FAIL rand_regs it=%0d got %h/%h/%h exp %h/%h/%h", it,
                   o_digits, dut_ctrl(), {o_addr, o_data},
                   exp_digits(), exp_ctrl(), {m_addr, m_data});
        end
      end
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (n_valid != exp_valid || n_err != exp_err ||
        o_digits !== exp_digits() || dut_ctrl() !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL rand_final got v=%0d e=%0d exp v=%0d e=%0d",
               n_valid, n_err, exp_valid, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_digit_write();
    test_control_regs();
    test_bad_length();
    test_reset_mid_frame();
    test_back_to_back();
    test_noop_unused();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
